// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// encoding and the access-counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache refill path and the load/store
// path: data normally wins, a starvation streak forces a pending refill through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [1:0]       STREAK_LIM = 2'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       streak_q, streak_d;
  logic             i_valid_q, i_valid_d;
  logic             d_valid_q, d_valid_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             grant_i;

  always_comb begin
    // NOTE: every _d starts from its hold value (valids from 0) so no branch
    // can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_i     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // A refill only beats a simultaneous data request once starved.
          grant_i     = i_req && (!d_req || streak_q == STREAK_LIM);
          mem_en_d    = 1'b1;
          cnt_d       = CNT_LOAD;
          mem_addr_d  = grant_i ? i_addr : d_addr;
          mem_wdata_d = d_wdata;
          if (grant_i) begin
            state_d  = BUSY_I;
            owner_d  = OWN_I;
            mem_we_d = 1'b0;
            streak_d = 2'd0;
          end else begin
            state_d  = BUSY_D;
            owner_d  = OWN_D;
            mem_we_d = d_we;
            if (i_req && streak_q != STREAK_LIM) begin
              streak_d = streak_q + 2'd1;
            end
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_we_q ? 32'd0 : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      cnt_q       <= '0;
      streak_q    <= 2'd0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_stall   = i_req & ~i_valid_q;
  assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared instruction/data memory port between the IF-stage instruction-cache refill path and the MEM-stage load/store path. It serialises transactions onto the memory, counts a fixed memory access latency, returns read data with a one-cycle valid pulse, and supplies stall levels to the pipeline. Data requests normally win; a starvation counter guarantees forward progress for refills.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles mem_en is held per access; legal range 1..15.
- STARVE_MAX, 2: consecutive contested data grants after which a pending refill wins; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- i_req  in  1  refill request (level), held until i_valid.
- i_addr  in  32  refill byte address, word aligned, stable while i_req.
- i_valid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  refill word.
- d_req  in  1  load/store request (level), held until d_valid.
- d_we  in  1  1 = store; stable while d_req.
- d_addr  in  32  data byte address, word aligned, stable while d_req.
- d_wdata  in  32  store data, stable while d_req.
- d_valid  out  1  one-cycle pulse: load data valid or store done.
- d_rdata  out  32  load word; 0 on store completion.
- i_stall  out  1  i_req & ~i_valid (combinational).
- d_stall  out  1  d_req & ~d_valid (combinational).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, only when mem_en.
- mem_addr  out  32  latched address; word index = mem_addr[31:2].
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  read data, valid in the last mem_en cycle.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: no request -> stay. Only d_req -> BUSY_D. Only i_req -> BUSY_I. Both: BUSY_I if streak == STARVE_MAX, else BUSY_D.
- Grant edge latches addr/we/wdata (we forced 0 for refill), loads cnt = MEM_LATENCY-1, records owner.
- streak (2-bit): on contested data grant (i_req also high) streak+1, saturating at STARVE_MAX; any instruction grant clears to 0; uncontested data grant leaves it unchanged.
- BUSY_x: mem_en=1, mem_we=latched we; cnt decrements each cycle; at cnt==0 capture mem_rdata (or 0 for store) into owner's rdata, pulse owner's valid, -> RESP.
- RESP: valid high this cycle only; mem_en=0; -> IDLE unconditionally. Requester must drop or change req during RESP; req still high in IDLE is a new transaction.
- i_rdata/d_rdata hold their last value between pulses.
- Request changes while BUSY are ignored until IDLE; the latched operands are used.

## Timing
- Reset values: state IDLE, i_valid=d_valid=0, i_rdata=d_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, streak=0, cnt=0.
- Req first seen in IDLE at cycle t -> mem_en cycles t+1..t+MEM_LATENCY -> valid at t+MEM_LATENCY+1 -> IDLE at t+MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Reset mid-access: next edge forces reset values; in-flight access abandoned, no valid pulse, store may not commit; mem_en drops that edge.
- Simultaneous req rise in IDLE resolved only by the streak rule above.

## Structure
- Package mem_arb_pkg: state enum, owner encoding (OWN_I, OWN_D), CNT_W = 4.
- Single module, no sub-module; counter and streak inline.

## Test plan
- Refill only, i_addr=0x10, mem_rdata=0xA5A5A5A5, MEM_LATENCY=2 -> mem_en cycles t+1,t+2, i_valid at t+3 with i_rdata=0xA5A5A5A5, i_stall low at t+3.
- Store d_addr=0x8, d_wdata=0x1234 -> mem_we=1, mem_addr=0x8 for 2 cycles, d_valid pulse, d_rdata=0.
- i_req and d_req held continuously, STARVE_MAX=2 -> grant order D, D, I, D, D, I.
- Load then immediately new load re-asserted in IDLE -> two transactions 4 cycles apart, addresses from each grant.
- Reset asserted in second BUSY_D cycle -> next cycle mem_en=0, d_valid never pulses, all outputs at reset values.
- MEM_LATENCY=1 refill -> valid at t+2, single mem_en cycle.
